// File: rtl/jt51_csr_ring.sv
// jt51_csr_ring: circulating per-channel control-word register for the FM core.
// Each channel's 26-bit word {rl, fb, con, kc, kf, ams, pms} circulates through
// a CH-deep ring that advances on cen. One posted write and one readback can
// be outstanding at a time. Both complete when the target channel is at the head.
module jt51_csr_ring #(
    parameter int CH  = 8,
    parameter int CHW = $clog2(CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic [7:0]     din,
    input  logic [CHW-1:0] wr_ch,
    input  logic [6:0]     wr_sel,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [CHW-1:0] rd_ch,
    input  logic           rd_valid,
    output logic           rd_ready,
    output logic [25:0]    rd_data,
    output logic           rd_done,
    output logic [CHW-1:0] slot,
    output logic [1:0]     rl,
    output logic [2:0]     fb,
    output logic [2:0]     con,
    output logic [6:0]     kc,
    output logic [5:0]     kf,
    output logic [1:0]     ams,
    output logic [2:0]     pms
);

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic [6:0]     sel;
        logic [7:0]     din;
    } wr_req_t;

    logic [25:0]    ring [CH];
    logic [25:0]    head, merged;
    wr_req_t        wr_q;
    logic           wr_pend, rd_pend;
    logic [CHW-1:0] rd_ch_q;
    logic           wr_hit, rd_hit;

    assign head     = ring[0];
    assign wr_ready = ~wr_pend;
    assign rd_ready = ~rd_pend;
    // Pending transactions only resolve on an advancing edge with their channel at the head
    assign wr_hit   = cen & wr_pend & (wr_q.ch == slot);
    assign rd_hit   = cen & rd_pend & (rd_ch_q == slot);

    assign {rl, fb, con, kc, kf, ams, pms} = head;

    // Head word with the pending write's selected fields overlaid
    always_comb begin
        merged = head;
        if (wr_pend && (wr_q.ch == slot)) begin
            if (wr_q.sel[6]) merged[25:24] = wr_q.din[7:6];
            if (wr_q.sel[5]) merged[23:21] = wr_q.din[5:3];
            if (wr_q.sel[4]) merged[20:18] = wr_q.din[2:0];
            if (wr_q.sel[3]) merged[17:11] = wr_q.din[6:0];
            if (wr_q.sel[2]) merged[10:5]  = wr_q.din[7:2];
            if (wr_q.sel[1]) merged[4:3]   = wr_q.din[1:0];
            if (wr_q.sel[0]) merged[2:0]   = wr_q.din[6:4];
        end
    end

    // Ring shift and slot counter; merged word re-enters at the tail
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) ring[i] <= '0;
            slot <= '0;
        end else if (cen) begin
            for (int i = 0; i < CH - 1; i++) ring[i] <= ring[i+1];
            ring[CH-1] <= merged;
            slot <= (slot == CHW'(CH - 1)) ? '0 : slot + 1'b1;
        end
    end

    // Posted write: latch on handshake, retire when applied at the head
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_pend <= 1'b0;
            wr_q    <= '0;
        end else if (wr_valid && !wr_pend) begin
            wr_pend <= 1'b1;
            wr_q    <= '{ch: wr_ch, sel: wr_sel, din: din};
        end else if (wr_hit) begin
            wr_pend <= 1'b0;
        end
    end

    // Readback: captures the merged word so a same-slot write is visible
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_ch_q <= '0;
            rd_data <= '0;
            rd_done <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (rd_valid && !rd_pend) begin
                rd_pend <= 1'b1;
                rd_ch_q <= rd_ch;
            end else if (rd_hit) begin
                rd_pend <= 1'b0;
                rd_data <= merged;
                rd_done <= 1'b1;
            end
        end
    end

endmodule

// File: doc/jt51_csr_ring.md
Name: jt51_csr_ring

Overview:
- Parametrised per-channel register ring for the FM core.
- Holds the 26-bit channel-control word (rl, fb, con, kc, kf, ams, pms) for CH channels in a circulating shift register advanced by cen.
- Presents the word of the channel currently in slot to the operator pipeline.
- Adds two things the fixed 8-channel version lacked:
  - Posted, handshaked writes to any channel, applied when that channel's slot comes round.
  - A handshaked readback port.

Parameters:
- CH, 8, number of channels in the ring (2..32).
- CHW, $clog2(CH), channel index width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- cen  in  1  clock enable; ring advance strobe
- din  in  8  write data byte
- wr_ch  in  CHW  target channel of write
- wr_sel  in  7  field update mask {rl, fb, con, kc, kf, ams, pms}, bit6 = rl
- wr_valid  in  1  write request
- wr_ready  out  1  write pending slot free
- rd_ch  in  CHW  channel to read back
- rd_valid  in  1  read request
- rd_ready  out  1  read pending slot free
- rd_data  out  26  readback word {rl, fb, con, kc, kf, ams, pms}
- rd_done  out  1  one-clk strobe: rd_data valid
- slot  out  CHW  channel index of current ring head
- rl  out  2  ring-head field
- fb  out  3  ring-head field
- con  out  3  ring-head field
- kc  out  7  ring-head field
- kf  out  6  ring-head field
- ams  out  2  ring-head field
- pms  out  3  ring-head field

Behaviour:
- Reset
  - rst_n low at a clk edge acts regardless of cen.
  - All CH ring stages clear to 0; slot = 0.
  - Write and read pendings are discarded.
  - wr_ready = 1, rd_ready = 1, rd_data = 0, rd_done = 0.
  - Field outputs are therefore 0.
- Din field mapping
  - rl = din[7:6], fb = din[5:3], con = din[2:0], kc = din[6:0], kf = din[7:2], ams = din[1:0], pms = din[6:4].
- Ring
  - Depth CH, width 26.
  - The head stage holds the word of channel slot; field outputs are combinational from the head.
  - On each clk edge with cen = 1:
    - The merged head word is pushed at the tail.
    - The ring shifts by one.
    - slot increments, wrapping CH-1 -> 0. CH need not be a power of 2.
  - cen = 0: ring and slot hold.
- Merge
  - merged = head word, with the fields whose wr_sel bit is set replaced by the din mapping.
  - Applies only when a write is pending and pend_ch == slot; otherwise merged = head.
  - A written channel shows new values at the head exactly CH cen edges after the applying edge.
- Write handshake
  - Accept on any clk edge with wr_valid & wr_ready, independent of cen.
  - On accept, latch din, wr_sel and wr_ch; wr_ready drops next cycle.
  - Applied on the first cen edge where slot == pend_ch, at least one edge after acceptance. No same-edge bypass.
  - wr_ready returns high the clk after apply.
  - Worst-case acceptance-to-apply: CH cen edges.
  - wr_sel = 0: write completes normally with no data change.
- Read handshake
  - Accept on rd_valid & rd_ready; latch rd_ch; rd_ready drops.
  - On the first subsequent cen edge with slot == rd_ch, rd_data <= merged, and rd_done pulses for one clk.
  - rd_ready returns high in the same clk as rd_done.
  - rd_data holds its value until the next read completes.
- Simultaneous events
  - Read and write pending to the same channel in the same slot: the read returns the post-write value.
  - A new request accepted on the clk where the previous one completes is not possible, because ready is low that edge.
  - Reset during any pending transaction aborts it with no partial update.
- Widths are exact; no arithmetic beyond the slot wrap compare.

Test Plan:
- Reset: hold rst_n low 2 clk with cen = 1, release -> slot = 0, all fields 0, wr_ready = rd_ready = 1, rd_done = 0. Then 8 cen edges -> slot sequence 0..7, 0.
- Single write, CH = 8: write wr_ch = 3, wr_sel = 7'b1110000 (rl, fb, con), din = 8'hC5 -> when slot = 3 a full rotation after apply: rl = 3, fb = 0, con = 5, others 0. wr_ready low from accept until apply.
- Partial update: preload channel 5 with kc = 7'h4A (din = 8'h4A, wr_sel = kc), then write kf with din = 8'hFC -> channel 5 reads kc = 7'h4A, kf = 6'h3F. No other channel changes.
- Readback with concurrent write: post write ch 2, ams = 2 (din = 8'h02); same cycle post read ch 2 -> rd_done at slot-2 edge, rd_data[4:3] = 2'b10, rd_ready and wr_ready high the next clk.
- cen gating and latency: cen every 4th clk, write ch 0 accepted while slot = 0 -> applied only at the next slot-0 edge (8 cen = 32 clk later), not at the current one.
- CH = 6 build: slot wraps 5 -> 0. Write ch 5, pms = 7 (din = 8'h70) -> visible at slot 5 after 6 cen edges. Reset asserted with a read pending -> rd_done never fires, rd_ready = 1.
